eth_tx_arbiter: RTL
===================

# eth_tx_arbiter

Shares the single GMII transmit port between two frame sources, e.g. the ARP frame generator and the UDP payload sender, on the `gmii_tx_clk` domain. It grants one requester at a time and forwards its byte stream to `gmii_tx_data`/`gmii_tx_en` through one register stage. It enforces the Ethernet inter-frame gap and aborts frames that underrun or exceed a length limit, flagging them with `gmii_tx_er`.

## Interface
- IFG_CYCLES, 12: minimum idle byte-times enforced after every frame; range 1..255.
- MAX_BYTES, 1526: byte-count limit per frame, preamble included; the frame is aborted on byte MAX_BYTES+1.
- gmii_tx_clk  in  1  sole clock, 125 MHz GMII byte clock.
- rst  in  1  synchronous, active-high reset.
- req[1:0]  in  2  frame request per source; held high until grant.
- gnt[1:0]  out  2  one-hot grant; high from grant cycle through the cycle `last` is accepted.
- s0_valid, s1_valid  in  1 each  byte valid from source 0 / 1.
- s0_data, s1_data  in  8 each  byte from source 0 / 1.
- s0_last, s1_last  in  1 each  final byte of frame, qualified by valid.
- gmii_tx_en  out  1  registered transmit enable.
- gmii_tx_er  out  1  registered transmit error; single-cycle pulse on abort.
- gmii_tx_data  out  8  registered transmit byte.
- busy  out  1  high in any state other than IDLE.
- abort_cnt  out  8  saturating count of aborted frames.

## Operation
- States: IDLE, GRANT, IFG.
- IDLE:
  - Samples `req`. If any bit is set, load `gnt` with the winner and go to GRANT next cycle.
  - Winner selection: fixed priority or round-robin (see Configuration).
- GRANT:
  - Each cycle, the granted source's valid/data are registered to `gmii_tx_en`/`gmii_tx_data`.
  - The byte counter increments per accepted byte.
  - The non-granted source's inputs are ignored entirely.
- Normal end: `valid && last` accepted → clear `gnt`, go to IFG.
- Underrun abort: valid low while in GRANT after at least one byte has been accepted → next cycle `gmii_tx_en`=1, `gmii_tx_er`=1, data 0x00. Clear `gnt`, increment `abort_cnt`, go to IFG.
- Valid low before the first byte is not an underrun; the arbiter waits in GRANT indefinitely.
- Oversize abort: byte counter reaching MAX_BYTES with `last` not yet seen → the next accepted byte is replaced by an error cycle, identical to an underrun abort.
- IFG: count IFG_CYCLES cycles, then return to IDLE. `req` is ignored during IFG.
- `abort_cnt` saturates at 255.

## Timing
- Reset values: `gnt`=0, `gmii_tx_en`=0, `gmii_tx_er`=0, `gmii_tx_data`=0x00, `busy`=0, `abort_cnt`=0, state IDLE, counters 0.
- Reset mid-frame: outputs go to reset values on the next edge, with no error cycle emitted.
- Grant latency: `req` sampled high in IDLE at cycle t → `gnt` high at t+1.
- Data latency: a byte accepted at cycle t appears on GMII at t+1.
- A source may drive valid in the same cycle `gnt` rises.
- Inter-frame gap: `last` accepted at t → IFG occupies t+1..t+IFG_CYCLES, and the next `gnt` is at t+IFG_CYCLES+2 at the earliest. `gmii_tx_en` is therefore low for at least IFG_CYCLES+1 consecutive cycles between frames.
- Simultaneous `req` in IDLE: resolved by the arbitration rule; the loser keeps `req` high and is served after the IFG.
- `last` on the first byte: a one-byte frame, which is legal.
- `gmii_tx_er` is never high while `gmii_tx_en` is low.

## Configuration
- ETH_TX_ARB_RR_EN defined: round-robin arbitration. On a tie, the source not granted most recently wins. The last-grant register resets to 1, so source 0 wins the first tie.
- ETH_TX_ARB_RR_EN undefined: fixed priority, source 0 always wins ties.
- All other behaviour is identical in both builds.

## Structure
- Shared package `eth_tx_pkg` holds:
  - the state enum (IDLE/GRANT/IFG);
  - the constants ETH_IFG_DEFAULT=12 and ETH_MAX_FRAME_DEFAULT=1526;
  - the GMII idle data value 0x00.
- One sub-module: `eth_tx_ifg_timer`, a loadable down-counter with `load`, `done` and a width of 8 bits.
- The byte counter, arbitration and output register stay in the top module.

## Test plan
- Single frame: source 0 sends 64 bytes 0x00..0x3F with `last` on 0x3F → the same 64 bytes appear on GMII one cycle later, `gmii_tx_en` is high for exactly 64 cycles, and `gmii_tx_er` stays 0.
- Simultaneous requests: both `req` bits rise in the same cycle → RR build serves 0 then 1, fixed build serves 0 then 1. With a repeated tie, RR serves 1 next while fixed serves 0.
- IFG: back-to-back frames with IFG_CYCLES=12 → 13 idle cycles between `gmii_tx_en` falling and rising again.
- Underrun: source 1 drops valid after 10 bytes → one cycle with `gmii_tx_en`=1, `gmii_tx_er`=1, data 0x00; `abort_cnt`=1; return to IDLE after the IFG.
- Oversize: MAX_BYTES=100 and a 120-byte stream → 100 bytes forwarded, then an error cycle, then `abort_cnt` increments.
- Reset mid-frame: `rst` pulsed for 1 cycle at byte 30 → all outputs 0 on the next edge, no `gmii_tx_er` pulse, and a new request is granted normally.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        IFG   = 2'd2
    } state_e;

    localparam int unsigned ETH_IFG_DEFAULT       = 12;
    localparam int unsigned ETH_MAX_FRAME_DEFAULT = 1526;
    localparam int unsigned IFG_W                 = 8;
    localparam int unsigned GMII_W                = 8;

    localparam logic [GMII_W-1:0] GMII_IDLE_DATA = 8'h00;

endpackage

// File: rtl/eth_tx_ifg_timer.sv
// Loadable down-counter timing the inter-frame gap; done rises on the last gap cycle.
module eth_tx_ifg_timer
    import eth_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IFG_W-1:0] value,
    output logic             done
);

    logic [IFG_W-1:0] cnt;

    // done is registered: it goes high in the value-th cycle after load
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= value - IFG_W'(1);
            done <= (value == IFG_W'(1));
        end else if (cnt != '0) begin
            cnt  <= cnt - IFG_W'(1);
            done <= (cnt == IFG_W'(1));
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Two-source GMII transmit arbiter with IFG enforcement and underrun/oversize abort.
// Define ETH_TX_ARB_RR_EN for round-robin tie-break; default is fixed priority to source 0.
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = ETH_IFG_DEFAULT,
    parameter int unsigned MAX_BYTES  = ETH_MAX_FRAME_DEFAULT
) (
    input  logic              gmii_tx_clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic              s0_valid,
    input  logic [GMII_W-1:0] s0_data,
    input  logic              s0_last,
    input  logic              s1_valid,
    input  logic [GMII_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              gmii_tx_en,
    output logic              gmii_tx_er,
    output logic [GMII_W-1:0] gmii_tx_data,
    output logic              busy,
    output logic [7:0]        abort_cnt
);

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

    state_e            state;
    logic [CNT_W-1:0]  byte_cnt;
    logic              ifg_done;

    logic              sel_valid_c;
    logic              sel_last_c;
    logic [GMII_W-1:0] sel_data_c;
    logic [1:0]        winner_c;
    logic              oversize_c;
    logic              underrun_c;
    logic              abort_c;
    logic              frame_end_c;

    // Only the granted source is ever looked at
    always_comb begin
        sel_valid_c = s0_valid;
        sel_data_c  = s0_data;
        sel_last_c  = s0_last;
        if (gnt[1]) begin
            sel_valid_c = s1_valid;
            sel_data_c  = s1_data;
            sel_last_c  = s1_last;
        end
    end

`ifdef ETH_TX_ARB_RR_EN
    logic last_gnt;

    always_comb begin
        winner_c = req;
        if (req == 2'b11) begin
            winner_c = last_gnt ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state == IDLE && req != 2'b00) begin
            last_gnt <= winner_c[1];
        end
    end
`else
    always_comb begin
        winner_c = req[0] ? 2'b01 : {req[1], 1'b0};
    end
`endif

    // An abort replaces the offending cycle; idle before the first byte is not an underrun
    always_comb begin
        oversize_c  = (byte_cnt == CNT_W'(MAX_BYTES));
        underrun_c  = !sel_valid_c && (byte_cnt != '0);
        abort_c     = (state == GRANT) && ((sel_valid_c && oversize_c) || underrun_c);
        frame_end_c = abort_c || ((state == GRANT) && sel_valid_c && sel_last_c);
    end

    eth_tx_ifg_timer u_ifg_timer (
        .clk   (gmii_tx_clk),
        .rst   (rst),
        .load  (frame_end_c),
        .value (IFG_W'(IFG_CYCLES)),
        .done  (ifg_done)
    );

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= 2'b00;
            busy         <= 1'b0;
            byte_cnt     <= '0;
            abort_cnt    <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            gmii_tx_data <= GMII_IDLE_DATA;
        end else begin
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            gmii_tx_data <= GMII_IDLE_DATA;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt      <= winner_c;
                        state    <= GRANT;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (abort_c) begin
                        gmii_tx_en <= 1'b1;
                        gmii_tx_er <= 1'b1;
                        gnt        <= 2'b00;
                        state      <= IFG;
                        abort_cnt  <= (abort_cnt == 8'hFF) ? abort_cnt : abort_cnt + 8'd1;
                    end else if (sel_valid_c) begin
                        gmii_tx_en   <= 1'b1;
                        gmii_tx_data <= sel_data_c;
                        byte_cnt     <= byte_cnt + CNT_W'(1);
                        if (sel_last_c) begin
                            gnt   <= 2'b00;
                            state <= IFG;
                        end
                    end
                end
                IFG: begin
                    if (ifg_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
